// File: rtl/h2c_lpbk_pkg.sv
// Shared types and default widths for the H2C loopback block.
package h2c_lpbk_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 256;
  localparam int unsigned DEF_PKT_WORDS_LEN = 8;
  localparam int unsigned DEF_QID_WIDTH     = 11;
  localparam int unsigned DEF_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with fully registered outputs and a registered ready.
// in_tvalid_i marks a write and is only honoured while in_tready_o is high.
module axis_skid_buf #(
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_tdata_i,
  input  logic                  in_tlast_i,
  input  logic                  in_tvalid_i,
  output logic                  in_tready_o,
  output logic [DATA_WIDTH-1:0] out_tdata_o,
  output logic                  out_tlast_o,
  output logic                  out_tvalid_o,
  input  logic                  out_tready_i
);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skd_data_q, skd_data_d;
  logic                  out_last_q, out_last_d, skd_last_q, skd_last_d;
  logic                  out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic                  rdy_q, rdy_d;
  logic                  in_hs;

  always_comb begin
    in_hs      = in_tvalid_i & rdy_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;
    skd_data_d = skd_data_q;
    skd_last_d = skd_last_q;
    skd_vld_d  = skd_vld_q;
    if (!out_vld_q || out_tready_i) begin
      // ready is low whenever the skid entry is full, so the skid entry and
      // a new input beat never compete for the output register
      if (skd_vld_q) begin
        out_data_d = skd_data_q;
        out_last_d = skd_last_q;
        out_vld_d  = 1'b1;
        skd_vld_d  = 1'b0;
      end else begin
        out_vld_d = in_hs;
        if (in_hs) begin
          out_data_d = in_tdata_i;
          out_last_d = in_tlast_i;
        end
      end
    end else if (in_hs) begin
      skd_data_d = in_tdata_i;
      skd_last_d = in_tlast_i;
      skd_vld_d  = 1'b1;
    end
    rdy_d = ~skd_vld_d;
  end

  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_last_q <= out_last_d;
    skd_data_q <= skd_data_d;
    skd_last_q <= skd_last_d;
    if (rst) begin
      out_vld_q <= 1'b0;
      skd_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      skd_vld_q <= skd_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  assign in_tready_o  = rdy_q;
  assign out_tdata_o  = out_data_q;
  assign out_tlast_o  = out_last_q;
  assign out_tvalid_o = out_vld_q;

endmodule

// File: rtl/h2c_lpbk.sv
// H2C-to-FIFO loopback: forwards packets of PKT_WORDS_LEN beats, drops errored ones.
// Statistics outputs are live only when H2C_LPBK_STATS_EN is defined.
module h2c_lpbk
  import h2c_lpbk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned PKT_WORDS_LEN = DEF_PKT_WORDS_LEN,
  parameter int unsigned QID_WIDTH     = DEF_QID_WIDTH,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] h2c_tdata,
  input  logic                  h2c_tvalid,
  input  logic                  h2c_tlast,
  output logic                  h2c_tready,
  input  logic [QID_WIDTH-1:0]  h2c_tuser_qid,
  input  logic                  h2c_tuser_err,
  input  logic                  h2c_tuser_zero_byte,
  input  logic [5:0]            h2c_tuser_mty,
  input  logic [31:0]           h2c_tcrc,
  output logic [DATA_WIDTH-1:0] fifo_s_axis_tdata,
  output logic                  fifo_s_axis_tvalid,
  output logic                  fifo_s_axis_tlast,
  input  logic                  fifo_s_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  len_err_cnt,
  output logic [QID_WIDTH-1:0]  last_qid
);

  localparam int unsigned BEAT_W = $clog2(PKT_WORDS_LEN) + 1;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                hs, sop_bad, at_max, fwd, fwd_last, len_err, drop_sop;

  always_comb begin
    hs       = h2c_tvalid & h2c_tready;
    sop_bad  = h2c_tuser_err | h2c_tuser_zero_byte;
    at_max   = (beat_q == BEAT_W'(PKT_WORDS_LEN - 1));
    fwd      = hs & (((state_q == IDLE) & ~sop_bad) | (state_q == RECV));
    fwd_last = h2c_tlast | at_max;
    // short packet (tlast early) or long packet (max index without tlast)
    len_err  = fwd & (h2c_tlast ^ at_max);
    drop_sop = hs & (state_q == IDLE) & sop_bad;
    state_d  = state_q;
    beat_d   = beat_q;
    if (fwd) begin
      beat_d  = fwd_last ? '0 : beat_q + BEAT_W'(1);
      state_d = h2c_tlast ? IDLE : (at_max ? DROP : RECV);
    end else if (hs) begin
      state_d = h2c_tlast ? IDLE : DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .in_tdata_i   (h2c_tdata),
    .in_tlast_i   (fwd_last),
    .in_tvalid_i  (fwd),
    .in_tready_o  (h2c_tready),
    .out_tdata_o  (fifo_s_axis_tdata),
    .out_tlast_o  (fifo_s_axis_tlast),
    .out_tvalid_o (fifo_s_axis_tvalid),
    .out_tready_i (fifo_s_axis_tready)
  );

`ifdef H2C_LPBK_STATS_EN
  logic [QID_WIDTH-1:0] sop_qid_q, last_qid_q, pkt_qid;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q, len_err_cnt_q;
  logic                 unused_ok;

  // a single-beat packet closes in IDLE, before sop_qid_q has been loaded
  assign pkt_qid = (state_q == IDLE) ? h2c_tuser_qid : sop_qid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sop_qid_q     <= '0;
      last_qid_q    <= '0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
      len_err_cnt_q <= '0;
    end else begin
      if (hs && (state_q == IDLE)) sop_qid_q <= h2c_tuser_qid;
      if (fwd && fwd_last) begin
        pkt_cnt_q  <= pkt_cnt_q + CNT_WIDTH'(1);
        last_qid_q <= pkt_qid;
      end
      if (drop_sop) drop_cnt_q    <= drop_cnt_q + CNT_WIDTH'(1);
      if (len_err)  len_err_cnt_q <= len_err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign pkt_cnt     = pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign len_err_cnt = len_err_cnt_q;
  assign last_qid    = last_qid_q;
  assign unused_ok   = ^{h2c_tuser_mty, h2c_tcrc};
`else
  logic unused_ok;

  assign pkt_cnt     = '0;
  assign drop_cnt    = '0;
  assign len_err_cnt = '0;
  assign last_qid    = '0;
  assign unused_ok   = ^{h2c_tuser_mty, h2c_tcrc, h2c_tuser_qid, len_err, drop_sop};
`endif

endmodule

// File: tb/tb_h2c_lpbk.sv
// Directed bench for h2c_lpbk: packet table plus back-to-back, stall and reset sequences.
module tb_h2c_lpbk;

  localparam int DW = 256;
  localparam int PL = 8;
  localparam int QW = 11;
  localparam int CW = 16;

`ifdef H2C_LPBK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk, rst;
  logic [DW-1:0] h2c_tdata;
  logic          h2c_tvalid, h2c_tlast, h2c_tready;
  logic [QW-1:0] h2c_tuser_qid;
  logic          h2c_tuser_err, h2c_tuser_zero_byte;
  logic [5:0]    h2c_tuser_mty;
  logic [31:0]   h2c_tcrc;
  logic [DW-1:0] fifo_tdata;
  logic          fifo_tvalid, fifo_tlast, fifo_tready;
  logic [CW-1:0] pkt_cnt, drop_cnt, len_err_cnt;
  logic [QW-1:0] last_qid;

  h2c_lpbk #(
    .DATA_WIDTH    (DW),
    .PKT_WORDS_LEN (PL),
    .QID_WIDTH     (QW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .h2c_tdata           (h2c_tdata),
    .h2c_tvalid          (h2c_tvalid),
    .h2c_tlast           (h2c_tlast),
    .h2c_tready          (h2c_tready),
    .h2c_tuser_qid       (h2c_tuser_qid),
    .h2c_tuser_err       (h2c_tuser_err),
    .h2c_tuser_zero_byte (h2c_tuser_zero_byte),
    .h2c_tuser_mty       (h2c_tuser_mty),
    .h2c_tcrc            (h2c_tcrc),
    .fifo_s_axis_tdata   (fifo_tdata),
    .fifo_s_axis_tvalid  (fifo_tvalid),
    .fifo_s_axis_tlast   (fifo_tlast),
    .fifo_s_axis_tready  (fifo_tready),
    .pkt_cnt             (pkt_cnt),
    .drop_cnt            (drop_cnt),
    .len_err_cnt         (len_err_cnt),
    .last_qid            (last_qid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;
  beat_t got[$];

  // FIFO ready: held high, or toggled every cycle when toggle_en is set
  bit toggle_en = 1'b0;
  initial begin
    fifo_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fifo_tready = toggle_en ? ~fifo_tready : 1'b1;
    end
  end

  // Output monitor: captures accepted beats and checks stability under stall
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", DW'(fifo_tvalid), DW'(1));
        chk("hold_data", fifo_tdata, prev_d);
        chk("hold_last", DW'(fifo_tlast), DW'(prev_l));
      end
      if (fifo_tvalid && fifo_tready) got.push_back('{fifo_tdata, fifo_tlast});
      prev_stall = fifo_tvalid && !fifo_tready;
      prev_d     = fifo_tdata;
      prev_l     = fifo_tlast;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] mkdata(input int seq, input int beat);
    logic [7:0] s, b;
    s = 8'(seq);
    b = 8'(beat);
    return DW'({16'hC0DE, s, b, 32'hA5A5_0000 + 32'(seq * 16 + beat)});
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives beats 0..stop-1 of an n-beat packet; entered and left at posedge+1
  task automatic send_pkt(input int seq, input int n, input int qid,
                          input bit err, input bit zero, input int stop);
    bit ok;
    int t;
    for (int i = 0; i < stop && i < n; i++) begin
      h2c_tvalid          = 1'b1;
      h2c_tdata           = mkdata(seq, i);
      h2c_tlast           = (i == n - 1);
      h2c_tuser_qid       = (i == 0) ? QW'(qid) : ~QW'(qid);
      h2c_tuser_err       = (i == 0) ? err : 1'b0;
      h2c_tuser_zero_byte = (i == 0) ? zero : 1'b0;
      t = 0;
      ok = 1'b0;
      while (!ok && t < 50) begin
        @(negedge clk);
        ok = h2c_tready;
        t++;
      end
      if (!ok) begin
        chk("h2c_ready_timeout", DW'(0), DW'(1));
        h2c_tvalid = 1'b0;
        h2c_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    h2c_tvalid = 1'b0;
    h2c_tlast  = 1'b0;
  endtask

  // Pops n beats of packet seq; last_idx is where tlast is expected (-1: nowhere)
  task automatic cmp_beats(input int seq, input int n, input int last_idx);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      if (got.size() == 0) break;
      b = got.pop_front();
      chk($sformatf("data_p%0d_b%0d", seq, i), b.d, mkdata(seq, i));
      chk($sformatf("last_p%0d_b%0d", seq, i), DW'(b.l), DW'(i == last_idx));
    end
  endtask

  int e_pkt = 0, e_drop = 0, e_len = 0, e_qid = 0;

  task automatic check_stats(input string tag);
    chk({tag, "_pkt_cnt"}, DW'(pkt_cnt), STATS ? DW'(CW'(e_pkt)) : DW'(0));
    chk({tag, "_drop_cnt"}, DW'(drop_cnt), STATS ? DW'(CW'(e_drop)) : DW'(0));
    chk({tag, "_len_err_cnt"}, DW'(len_err_cnt), STATS ? DW'(CW'(e_len)) : DW'(0));
    chk({tag, "_last_qid"}, DW'(last_qid), STATS ? DW'(QW'(e_qid)) : DW'(0));
  endtask

  typedef struct {
    int n;
    int qid;
    bit err;
    bit zero;
    bit tog;
    int exp_fwd;
    int exp_pkt;
    int exp_drop;
    int exp_len;
  } vec_t;
  vec_t vt[7];

  initial begin
    //          n   qid err zero tog fwd pkt drop len
    vt[0] = '{  8,   5, 0,  0,   0,  8,  1,  0,   0};
    vt[1] = '{  3,   7, 0,  0,   0,  3,  1,  0,   1};
    vt[2] = '{ 11,   9, 0,  0,   0,  8,  1,  0,   1};
    vt[3] = '{  8,  10, 0,  0,   0,  8,  1,  0,   0};
    vt[4] = '{  4,   3, 1,  0,   0,  0,  0,  1,   0};
    vt[5] = '{  1,   4, 0,  1,   0,  0,  0,  1,   0};
    vt[6] = '{  8,  12, 0,  0,   1,  8,  1,  0,   0};

    rst                 = 1'b1;
    h2c_tvalid          = 1'b0;
    h2c_tlast           = 1'b0;
    h2c_tdata           = '0;
    h2c_tuser_qid       = '0;
    h2c_tuser_err       = 1'b0;
    h2c_tuser_zero_byte = 1'b0;
    h2c_tuser_mty       = 6'h2A;
    h2c_tcrc            = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_h2c_tready", DW'(h2c_tready), DW'(0));
    chk("rst_fifo_tvalid", DW'(fifo_tvalid), DW'(0));
    check_stats("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_low_first_cycle", DW'(h2c_tready), DW'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_rises_after_rst", DW'(h2c_tready), DW'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      toggle_en = vt[i].tog;
      send_pkt(i, vt[i].n, vt[i].qid, vt[i].err, vt[i].zero, vt[i].n);
      wait_cycles(12);
      toggle_en = 1'b0;
      wait_cycles(3);
      chk($sformatf("fwd_count_p%0d", i), DW'(got.size()), DW'(vt[i].exp_fwd));
      cmp_beats(i, vt[i].exp_fwd, vt[i].exp_fwd - 1);
      got.delete();
      e_pkt  += vt[i].exp_pkt;
      e_drop += vt[i].exp_drop;
      e_len  += vt[i].exp_len;
      if (vt[i].exp_pkt != 0) e_qid = vt[i].qid;
      check_stats($sformatf("vec%0d", i));
    end

    // back-to-back packets with FIFO ready toggling every cycle
    toggle_en = 1'b1;
    send_pkt(20, 8, 21, 1'b0, 1'b0, 8);
    send_pkt(21, 8, 22, 1'b0, 1'b0, 8);
    wait_cycles(20);
    toggle_en = 1'b0;
    wait_cycles(3);
    chk("b2b_fwd_count", DW'(got.size()), DW'(16));
    cmp_beats(20, 8, 7);
    cmp_beats(21, 8, 7);
    got.delete();
    e_pkt += 2;
    e_qid = 22;
    check_stats("b2b");

    // reset during beat 4 of an 8-beat packet
    send_pkt(30, 8, 31, 1'b0, 1'b0, 4);
    h2c_tvalid    = 1'b1;
    h2c_tdata     = mkdata(30, 4);
    h2c_tuser_qid = ~QW'(31);
    rst           = 1'b1;
    @(posedge clk);
    #1;
    h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("midrst_h2c_tready", DW'(h2c_tready), DW'(0));
    chk("midrst_fifo_tvalid", DW'(fifo_tvalid), DW'(0));
    e_pkt  = 0;
    e_drop = 0;
    e_len  = 0;
    e_qid  = 0;
    check_stats("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(4);
    chk("midrst_partial_count", DW'(got.size()), DW'(3));
    cmp_beats(30, 3, -1);
    got.delete();

    send_pkt(40, 8, 41, 1'b0, 1'b0, 8);
    wait_cycles(6);
    chk("post_rst_fwd_count", DW'(got.size()), DW'(8));
    cmp_beats(40, 8, 7);
    got.delete();
    e_pkt = 1;
    e_qid = 41;
    check_stats("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
